// File: rtl/mealy_bit_conditioner_if.sv
// Signal bundle between the step/bit conditioner and its user (detector or bench).
// The master drives the raw switch/button and enable; the slave returns the bit strobe and displays.
interface mealy_bit_conditioner_if;
  logic       ena;
  logic       din_raw;
  logic       step_raw;
  logic       bit_valid;
  logic       bit_data;
  logic [7:0] history;
  logic [7:0] bit_count;
  logic [1:0] dbg_state;

  // bit_valid is a push-only strobe with no ready: the consumer must take
  // bit_data in the single cycle bit_valid=1; bit_data then holds until the next strobe.
  modport master (
    output ena, din_raw, step_raw,
    input  bit_valid, bit_data, history, bit_count, dbg_state
  );

  modport slave (
    input  ena, din_raw, step_raw,
    output bit_valid, bit_data, history, bit_count, dbg_state
  );
endinterface

// File: rtl/mealy_bit_conditioner.sv
// Debounces the step button into one bit strobe per press, capturing the synchronized bit switch,
// and keeps an 8-bit shift history plus a saturating press counter.
module mealy_bit_conditioner #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input logic                    clk,
  input logic                    rst_n,
  mealy_bit_conditioner_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  logic [1:0]       r_din_sync;
  logic [1:0]       r_step_sync;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bit_valid;
  logic             r_bit_data;
  logic [7:0]       r_history;
  logic [7:0]       r_bit_count;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_accept;
  logic             w_din_s;
  logic             w_step_s;

  assign w_din_s  = r_din_sync[1];
  assign w_step_s = r_step_sync[1];

  // Synchronizers run independently of ena so the inputs are settled when ena returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din_sync  <= 2'b00;
      r_step_sync <= 2'b00;
    end else begin
      r_din_sync  <= {r_din_sync[0], bus.din_raw};
      r_step_sync <= {r_step_sync[0], bus.step_raw};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_accept     = 1'b0;
    if (!bus.ena) begin
      w_next_state = S_IDLE;
      w_next_cnt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_step_s) begin
            w_next_state = S_PRESS_WAIT;
            w_next_cnt   = '0;
          end
        end
        S_PRESS_WAIT: begin
          if (!w_step_s) begin
            w_next_state = S_IDLE;
          end else if (r_cnt == CNT_MAX) begin
            w_next_state = S_HELD;
            w_accept     = 1'b1;
          end else begin
            w_next_cnt = r_cnt + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (!w_step_s) begin
            w_next_state = S_RELEASE_WAIT;
            w_next_cnt   = '0;
          end
        end
        S_RELEASE_WAIT: begin
          if (w_step_s) begin
            w_next_state = S_HELD;
          end else if (r_cnt == CNT_MAX) begin
            w_next_state = S_IDLE;
          end else begin
            w_next_cnt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_next_state = S_IDLE;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  // Data, history and count move only on acceptance, so they hold through ena=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_valid <= 1'b0;
      r_bit_data  <= 1'b0;
      r_history   <= 8'h00;
      r_bit_count <= 8'h00;
    end else begin
      r_bit_valid <= w_accept;
      if (w_accept) begin
        r_bit_data <= w_din_s;
        r_history  <= {r_history[6:0], w_din_s};
        if (r_bit_count != 8'hFF) begin
          r_bit_count <= r_bit_count + 8'd1;
        end
      end
    end
  end

  assign bus.bit_valid = r_bit_valid;
  assign bus.bit_data  = r_bit_data;
  assign bus.history   = r_history;
  assign bus.bit_count = r_bit_count;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_mealy_bit_conditioner.sv
// Directed plus randomized bench for mealy_bit_conditioner with DEBOUNCE_CYCLES=4,
// compared every cycle against a run-length reference model and a bit scoreboard.
module tb_mealy_bit_conditioner;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mealy_bit_conditioner_if bus ();

  mealy_bit_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_strobes = 0;

  // Reference model: a press is accepted when the synchronized button has been high
  // for D+1 consecutive enabled edges while armed; re-arming needs D+1 consecutive lows.
  logic       m_s1 = 1'b0, m_s2 = 1'b0, m_d1 = 1'b0, m_d2 = 1'b0;
  bit         armed = 1'b1;
  int         run_hi = 0, run_lo = 0;
  logic       m_valid = 1'b0, m_data = 1'b0;
  logic [7:0] m_hist = 8'h00;
  int         m_total = 0;
  logic [0:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_d1 <= 1'b0; m_d2 <= 1'b0;
      armed <= 1'b1; run_hi <= 0; run_lo <= 0;
      m_valid <= 1'b0; m_data <= 1'b0; m_hist <= 8'h00; m_total <= 0;
      exp_q.delete();
    end else begin : mdl
      int hi, lo;
      bit arm, acc;
      hi = run_hi; lo = run_lo; arm = armed; acc = 1'b0;
      if (!bus.ena) begin
        arm = 1'b1; hi = 0; lo = 0;
      end else if (m_s2) begin
        lo = 0; hi = hi + 1;
        if (arm && hi == D + 1) begin
          acc = 1'b1; arm = 1'b0;
        end
      end else begin
        hi = 0; lo = lo + 1;
        if (!arm && lo == D + 1) arm = 1'b1;
      end
      run_hi <= hi; run_lo <= lo; armed <= arm;
      m_valid <= acc;
      if (acc) begin
        m_data  <= m_d2;
        m_hist  <= {m_hist[6:0], m_d2};
        m_total <= m_total + 1;
        exp_q.push_back(m_d2);
      end
      m_s2 <= m_s1; m_s1 <= bus.step_raw;
      m_d2 <= m_d1; m_d1 <= bus.din_raw;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic [7:0] exp_cnt;
    exp_cnt = (m_total > 255) ? 8'hFF : 8'(m_total);
    chk("bit_valid", 32'(bus.bit_valid), 32'(m_valid));
    chk("bit_data",  32'(bus.bit_data),  32'(m_data));
    chk("history",   32'(bus.history),   32'(m_hist));
    chk("bit_count", 32'(bus.bit_count), 32'(exp_cnt));
    if (bus.bit_valid === 1'b1) begin
      n_strobes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $error("FAIL sb_unexpected: observed=strobe expected=none");
      end else begin
        chk("sb_bit", 32'(bus.bit_data), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cycle();
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.ena = 1'b1; bus.step_raw = 1'b0; bus.din_raw = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_strobes = 0;
    chk("rst_valid", 32'(bus.bit_valid), 32'd0);
    chk("rst_data",  32'(bus.bit_data),  32'd0);
    chk("rst_hist",  32'(bus.history),   32'd0);
    chk("rst_count", 32'(bus.bit_count), 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'd0);
  endtask

  // Full press + debounced release; din is scrambled while held to prove it is ignored.
  task automatic press(input logic b, input int hold, input int rel);
    bus.din_raw = b;
    bus.step_raw = 1'b1;
    step(D + 3);
    bus.din_raw = 1'($urandom_range(0, 1));
    step(hold);
    bus.step_raw = 1'b0;
    step(D + 3 + rel);
  endtask

  initial begin
    logic [7:0] seq_bits;
    bus.ena = 1'b1; bus.din_raw = 1'b0; bus.step_raw = 1'b0;
    seq_bits = 8'b10110010;

    // Basic press
    apply_reset();
    bus.din_raw = 1'b1;
    bus.step_raw = 1'b1;
    step(6);
    chk("basic_before_edge7", 32'(bus.bit_valid), 32'd0);
    step(1);
    chk("basic_edge7", 32'(bus.bit_valid), 32'd1);
    chk("basic_data", 32'(bus.bit_data), 32'd1);
    step(1);
    chk("basic_fall", 32'(bus.bit_valid), 32'd0);
    step(12);
    chk("basic_strobes", 32'(n_strobes), 32'd1);
    chk("basic_hist", 32'(bus.history), 32'h01);
    chk("basic_count", 32'(bus.bit_count), 32'd1);

    // Glitch rejection
    apply_reset();
    bus.din_raw = 1'b1;
    bus.step_raw = 1'b1;
    step(3);
    bus.step_raw = 1'b0;
    step(20);
    chk("glitch_strobes", 32'(n_strobes), 32'd0);
    chk("glitch_hist", 32'(bus.history), 32'h00);
    chk("glitch_count", 32'(bus.bit_count), 32'd0);

    // Release bounce
    apply_reset();
    bus.din_raw = 1'b1;
    bus.step_raw = 1'b1;
    step(D + 5);
    bus.step_raw = 1'b0; step(1);
    bus.step_raw = 1'b1; step(1);
    bus.step_raw = 1'b0; step(1);
    bus.step_raw = 1'b1; step(1);
    bus.step_raw = 1'b0; step(10);
    press(1'b0, 2, 2);
    chk("bounce_strobes", 32'(n_strobes), 32'd2);
    chk("bounce_hist", 32'(bus.history), 32'h02);
    chk("bounce_count", 32'(bus.bit_count), 32'd2);

    // Sequence then saturation with random bits and timing
    apply_reset();
    for (int i = 7; i >= 0; i--) press(seq_bits[i], 1, 0);
    chk("seq_hist", 32'(bus.history), 32'hB2);
    chk("seq_count", 32'(bus.bit_count), 32'd8);
    for (int i = 0; i < 250; i++)
      press(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    chk("sat_count", 32'(bus.bit_count), 32'hFF);
    chk("sat_strobes", 32'(n_strobes), 32'd258);

    // ena drop during PRESS_WAIT, re-enable with button held
    apply_reset();
    bus.din_raw = 1'b1;
    bus.step_raw = 1'b1;
    step(3);
    bus.ena = 1'b0;
    step(10);
    chk("ena_no_strobe", 32'(n_strobes), 32'd0);
    chk("ena_state", 32'(bus.dbg_state), 32'd0);
    bus.ena = 1'b1;
    step(D);
    chk("ena_before", 32'(bus.bit_valid), 32'd0);
    step(1);
    chk("ena_strobe", 32'(bus.bit_valid), 32'd1);
    step(10);
    chk("ena_strobes", 32'(n_strobes), 32'd1);

    // Async reset in the middle of a press
    apply_reset();
    press(1'b1, 1, 0);
    bus.din_raw = 1'b1;
    bus.step_raw = 1'b1;
    step(4);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", 32'(bus.bit_valid), 32'd0);
    chk("areset_data",  32'(bus.bit_data),  32'd0);
    chk("areset_hist",  32'(bus.history),   32'd0);
    chk("areset_count", 32'(bus.bit_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_strobes = 0;
    step(6);
    chk("areset_before", 32'(bus.bit_valid), 32'd0);
    step(1);
    chk("areset_strobe", 32'(bus.bit_valid), 32'd1);
    step(8);
    chk("areset_strobes", 32'(n_strobes), 32'd1);
    chk("areset_count_after", 32'(bus.bit_count), 32'd1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mealy_bit_conditioner.md
Name: mealy_bit_conditioner

Overview:
- Input-conditioning stage directly upstream of the Mealy sequence detector.
- Converts the raw bit-value switch and the "step" push-button into one clean bit strobe per debounced press: `bit_valid` plus `bit_data`, which the detector consumes as its serial input.
- Also keeps an 8-bit shift history and a press counter for display on spare outputs.

Parameters:
- DEBOUNCE_CYCLES, 100000, number of consecutive stable cycles needed to accept a press or release (10 ms at 10 MHz); legal range ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of the debounce counter. Derived; never overridden.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; low forces FSM to IDLE
- din_raw  input  1  asynchronous bit-value switch
- step_raw  input  1  asynchronous step push-button, active high
- bit_valid  output  1  one-cycle strobe: a new bit is available
- bit_data  output  1  accepted bit value; valid while bit_valid=1, held until the next strobe
- history  output  8  last 8 accepted bits; newest in bit 0
- bit_count  output  8  number of accepted bits, saturating at 255

Behaviour:
- Reset (async, rst_n=0):
  - All flops clear immediately: synchronizers, FSM=IDLE, counter=0.
  - Outputs: bit_valid=0, bit_data=0, history=8'h00, bit_count=0.
  - Reset mid-operation discards any press in progress; no strobe is issued.
- Synchronizers:
  - din_raw and step_raw each pass through 2 flops, giving din_s and step_s.
  - The synchronizers keep running regardless of ena.
- FSM states:
  - IDLE
    - step_s=1: go to PRESS_WAIT, cnt=0.
  - PRESS_WAIT
    - step_s=0: go to IDLE (glitch rejected, no strobe).
    - step_s=1 and cnt<DEBOUNCE_CYCLES-1: cnt+1.
    - step_s=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD, register bit_valid=1 and bit_data=din_s.
  - HELD
    - step_s=0: go to RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT
    - step_s=1: go back to HELD (release bounce, no new strobe).
    - step_s=0 and cnt<DEBOUNCE_CYCLES-1: cnt+1.
    - step_s=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE.
- Strobe timing:
  - bit_valid is registered and high for exactly one cycle per accepted press.
  - Number the first rising edge that samples step_raw=1 as edge 1, with step_raw held high from then on. bit_valid rises after edge DEBOUNCE_CYCLES+3 and falls after the next edge.
  - A held button never produces a second strobe. A new strobe requires a full debounced release followed by a new debounced press.
- Data capture:
  - bit_data = din_s sampled on the same edge that sets bit_valid.
  - din changes while HELD do not affect bit_data.
- Side outputs, updated on the same edge as bit_valid:
  - history <= {history[6:0], accepted bit}.
  - bit_count increments by 1 and saturates at 8'hFF (no wrap).
- ena=0:
  - FSM forced to IDLE, cnt=0, bit_valid forced to 0.
  - bit_data, history and bit_count hold their values.
  - Deasserting ena during PRESS_WAIT cancels the press.
  - On ena re-assert with the button still held, the FSM starts from IDLE and the held button is treated as a new press, yielding one strobe after the full debounce time.
- Simultaneous events:
  - din_raw changing in the same cycle as acceptance: the value captured is whatever din_s holds at that edge.
  - 2-flop latency applies to both inputs equally, so the din change is not visible in the same cycle.
- Counter range:
  - cnt never exceeds DEBOUNCE_CYCLES-1.
  - CNT_W is derived as $clog2(DEBOUNCE_CYCLES) so it can hold DEBOUNCE_CYCLES-1.

Test Plan (all with DEBOUNCE_CYCLES=4):
- Basic press: din_raw=1, step_raw 0→1 and held 20 cycles → one bit_valid pulse after edge 7, bit_data=1, history=8'h01, bit_count=1, no further pulses while held.
- Glitch rejection: step_raw high for 3 cycles, then low 20 cycles → bit_valid never asserted; history, bit_count unchanged.
- Bounce: press accepted, then release with step_raw toggling 1-0-1-0 each cycle, then low 10 cycles, then a clean press with din_raw=0 → exactly 2 strobes total, history=8'h02, bit_count=2.
- Sequence: 8 clean presses with bits 1,0,1,1,0,0,1,0 → history=8'b10110010, bit_count=8; then 250 more presses → bit_count saturates at 8'hFF.
- ena drop: assert step_raw, pull ena low after 3 cycles → no strobe; raise ena with step_raw still high → one strobe 5 cycles later (DEBOUNCE_CYCLES+1 edges after ena rises; 2-flop synchronizer already settled).
- Async reset mid-PRESS_WAIT: rst_n low between clock edges → all outputs 0 immediately, no strobe; after release of reset, a held button yields a strobe after the full debounce time.
